wb_port_arbiter: RTL and testbench
==================================

WB_PORT_ARBITER -- requirements
Module: wb_port_arbiter

Interface
REQ-001 SHALL have one clock `clk` and a synchronous, active-high reset `rst`; all state changes on the rising edge of `clk`.
REQ-002 Ports, one per line; `clk` and `rst` first; widths from the shared defines header (`R_SIZE = 5 bits, `D_SIZE = 32 bits):
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- p_we  in  1  pipeline writeback enable
- p_wa  in  `R_SIZE  pipeline write address, already rt/rd-selected
- p_wd  in  `D_SIZE  pipeline write data
- m_valid  in  1  multicycle-unit result valid
- m_wa  in  `R_SIZE  multicycle result address
- m_wd  in  `D_SIZE  multicycle result data
- m_ready  out  1  queue can accept a result
- stall_req  out  1  pipeline must hold this cycle
- rf_we  out  1  register-file write enable
- rf_wa  out  `R_SIZE  register-file write address
- rf_wd  out  `D_SIZE  register-file write data
- pending  out  1  queue non-empty
REQ-003 SHALL take one parameter: STARVE_LIMIT, default `WB_STARVE_LIMIT (4), meaning the maximum number of cycles a live queue head may wait before being forced.

Function
REQ-004 SHALL share the single register-file write port between the pipeline and a 2-entry FIFO of multicycle results.
REQ-005 SHALL accept a multicycle result on any edge where m_valid=1 and m_ready=1.
REQ-006 m_ready SHALL be 1 when count<2, derived from registered count only, with no combinational path from any input.
REQ-007 An accepted result SHALL NOT be pushed if m_wa=0, or if this cycle's pipeline write (p_we=1, stall_req=0) targets the same address.
REQ-008 Each entry SHALL hold {wa, wd, kill}; kill=0 on push.
REQ-009 A live pipeline write (p_we=1, p_wa!=0, stall_req=0) SHALL set kill on every queued entry whose wa equals p_wa.
REQ-010 Write-port selection, combinational, in priority order:
- (a) state FORCE: port driven from queue head;
- (b) live pipeline write: port driven from pipeline;
- (c) count>0: port driven from queue head;
- (d) otherwise rf_we=0, rf_wa=0, rf_wd=0.
REQ-011 When the head drives the port, rf_we SHALL equal the inverse of head.kill and the head SHALL be popped at that edge.
REQ-012 A killed head SHALL also be popped silently in any cycle where the pipeline owns the port.
REQ-013 p_we with p_wa=0 SHALL produce no write and SHALL NOT block the head.
REQ-014 Push and pop SHALL be allowed on the same edge; when full, a pop does not raise m_ready in the same cycle.
REQ-015 FSM states:
- IDLE (count=0)
- WAIT (count>0, head waiting)
- FORCE (stall_req=1 for exactly one cycle)
REQ-016 FSM transitions:
- IDLE->WAIT on push.
- WAIT: starvation counter increments each cycle the head is not popped and clears on pop.
- WAIT->FORCE when the counter reaches STARVE_LIMIT-1 without a pop.
- FORCE->WAIT if count>0 after the pop, else FORCE->IDLE.
REQ-017 In FORCE, p_we SHALL be ignored; the pipeline re-presents the write next cycle.
REQ-018 A head killed on the cycle entering FORCE SHALL be popped silently in FORCE, with stall_req still 1.
REQ-019 pending SHALL equal (count!=0).

Reset
REQ-020 While rst=1 at an edge, the block SHALL set count=0, state=IDLE, starvation counter=0 and clear all kill bits.
REQ-021 While rst=1, outputs SHALL be m_ready=0, stall_req=0, rf_we=0 and pending=0; m_ready=1 on the first cycle after reset.
REQ-022 Reset SHALL override any simultaneous push, pop or FORCE.

Structure
REQ-023 `R_SIZE, `D_SIZE, `WB_STARVE_LIMIT and the FSM state encodings SHALL live in the shared defines.vh.
REQ-024 The FIFO SHALL be a sub-module wb_fifo (depth 2, push/pop/kill-match ports); the FSM and selection logic stay in wb_port_arbiter.

Verification
REQ-025 Idle port: p_we=1, p_wa=8, p_wd=0xAA, no m_valid -> rf_we=1, rf_wa=8, rf_wd=0xAA same cycle; pending=0.
REQ-026 Gap fill: push (wa=3, wd=0x11) with p_we=0 next cycle -> rf_we=1, rf_wa=3, rf_wd=0x11 that cycle; pending=0 after.
REQ-027 Starvation: push (wa=5, wd=0x22), then p_we=1 with p_wa=9 continuously -> stall_req=1 exactly 4 cycles after the push, rf_wa=5 in that cycle, pipeline writes resume next cycle.
REQ-028 Squash: queue (wa=7, wd=0x33), then pipeline write p_wa=7, p_wd=0x44 -> register 7 written only with 0x44; the entry is popped with no write.
REQ-029 Full/zero/reset: push 2 entries -> m_ready=0; push with m_wa=0 -> not queued; rst=1 with 2 queued -> pending=0, rf_we=0 next cycle.

Source files
------------

// File: rtl/wb_port_arbiter_pkg.sv
// Shared widths, starvation default, FSM encoding and queue entry layout
// for the register-file write-port arbiter.
package wb_port_arbiter_pkg;

    localparam int R_SIZE          = 5;
    localparam int D_SIZE          = 32;
    localparam int WB_STARVE_LIMIT = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_FORCE = 2'd2
    } state_t;

    typedef struct packed {
        logic [R_SIZE-1:0] wa;
        logic [D_SIZE-1:0] wd;
        logic              kill;
    } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Two-entry queue of multicycle results; slot0 is always the head.
// Entries whose address matches a live pipeline write are marked killed.
module wb_fifo
    import wb_port_arbiter_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [R_SIZE-1:0] push_wa,
    input  logic [D_SIZE-1:0] push_wd,
    input  logic              pop,
    input  logic              kill_en,
    input  logic [R_SIZE-1:0] kill_wa,
    output logic [R_SIZE-1:0] head_wa,
    output logic [D_SIZE-1:0] head_wd,
    output logic              head_kill,
    output logic [1:0]        count
);

    wb_entry_t   slot0;
    wb_entry_t   slot1;
    logic        k0;
    logic        k1;
    logic        do_pop;
    logic        do_push;
    logic [1:0]  fill;
    logic        wr0;
    logic        wr1;

    always_comb begin
        k0      = slot0.kill | (kill_en && (slot0.wa == kill_wa));
        k1      = slot1.kill | (kill_en && (slot1.wa == kill_wa));
        do_pop  = pop && (count != 2'd0);
        do_push = push && ((count != 2'd2) || do_pop);
        fill    = count - {1'b0, do_pop};
        wr0     = do_push && (fill == 2'd0);
        wr1     = do_push && (fill == 2'd1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            slot0 <= '0;
            slot1 <= '0;
            count <= 2'd0;
        end else begin
            if (wr0)
                slot0 <= '{wa: push_wa, wd: push_wd, kill: 1'b0};
            else if (do_pop)
                slot0 <= '{wa: slot1.wa, wd: slot1.wd, kill: k1};
            else
                slot0.kill <= k0;

            if (wr1)
                slot1 <= '{wa: push_wa, wd: push_wd, kill: 1'b0};
            else
                slot1.kill <= k1;

            count <= count + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

    assign head_wa   = slot0.wa;
    assign head_wd   = slot0.wd;
    assign head_kill = slot0.kill;

endmodule

// File: rtl/wb_port_arbiter.sv
// Shares the single register-file write port between the pipeline and
// queued multicycle results, forcing a stall when the head starves.
module wb_port_arbiter
    import wb_port_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = WB_STARVE_LIMIT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              p_we,
    input  logic [R_SIZE-1:0] p_wa,
    input  logic [D_SIZE-1:0] p_wd,
    input  logic              m_valid,
    input  logic [R_SIZE-1:0] m_wa,
    input  logic [D_SIZE-1:0] m_wd,
    output logic              m_ready,
    output logic              stall_req,
    output logic              rf_we,
    output logic [R_SIZE-1:0] rf_wa,
    output logic [D_SIZE-1:0] rf_wd,
    output logic              pending
);

    localparam int SW = $clog2(STARVE_LIMIT) + 1;
    localparam logic [SW-1:0] STARVE_TOP = SW'(STARVE_LIMIT - 1);

    state_t            state;
    state_t            state_n;
    logic [SW-1:0]     starve;
    logic [SW-1:0]     starve_n;
    logic [SW-1:0]     starve_inc;
    logic [1:0]        count;
    logic [1:0]        count_n;
    logic [R_SIZE-1:0] head_wa;
    logic [D_SIZE-1:0] head_wd;
    logic              head_kill;
    logic              in_force;
    logic              live_p;
    logic              same_wa;
    logic              push;
    logic              pop;
    logic              sel_force;
    logic              sel_pipe;
    logic              sel_head;
    logic              we_c;
    logic [R_SIZE-1:0] wa_c;
    logic [D_SIZE-1:0] wd_c;

    // rst only masks the outputs; ready itself depends on registered count
    assign m_ready  = !rst && (count != 2'd2);
    assign in_force = (state == ST_FORCE);
    assign live_p   = p_we && (p_wa != '0) && !in_force;
    assign same_wa  = p_we && !in_force && (p_wa == m_wa);
    assign push     = m_valid && m_ready && (m_wa != '0) && !same_wa;

    assign sel_force = in_force && (count != 2'd0);
    assign sel_pipe  = live_p;
    assign sel_head  = !in_force && !live_p && (count != 2'd0);

    always_comb begin
        we_c = 1'b0;
        wa_c = '0;
        wd_c = '0;
        pop  = 1'b0;
        unique case (1'b1)
            sel_force, sel_head: begin
                we_c = !head_kill;
                wa_c = head_wa;
                wd_c = head_wd;
                pop  = 1'b1;
            end
            sel_pipe: begin
                we_c = 1'b1;
                wa_c = p_wa;
                wd_c = p_wd;
                pop  = (count != 2'd0) && head_kill;
            end
            default: ;
        endcase
    end

    wb_fifo u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_wa   (m_wa),
        .push_wd   (m_wd),
        .pop       (pop),
        .kill_en   (live_p),
        .kill_wa   (p_wa),
        .head_wa   (head_wa),
        .head_wd   (head_wd),
        .head_kill (head_kill),
        .count     (count)
    );

    assign count_n    = count + {1'b0, push} - {1'b0, pop};
    assign starve_inc = starve + SW'(1);

    always_comb begin
        state_n  = state;
        starve_n = starve;
        unique case (state)
            ST_IDLE: begin
                starve_n = '0;
                if (push)
                    state_n = ST_WAIT;
            end
            ST_WAIT: begin
                if (pop) begin
                    starve_n = '0;
                    if (count_n == 2'd0)
                        state_n = ST_IDLE;
                end else if (starve_inc == STARVE_TOP) begin
                    starve_n = '0;
                    state_n  = ST_FORCE;
                end else begin
                    starve_n = starve_inc;
                end
            end
            ST_FORCE: begin
                starve_n = '0;
                state_n  = (count_n != 2'd0) ? ST_WAIT : ST_IDLE;
            end
            default: begin
                starve_n = '0;
                state_n  = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_IDLE;
            starve <= '0;
        end else begin
            state  <= state_n;
            starve <= starve_n;
        end
    end

    assign stall_req = !rst && in_force;
    assign rf_we     = !rst && we_c;
    assign rf_wa     = rst ? '0 : wa_c;
    assign rf_wd     = rst ? '0 : wd_c;
    assign pending   = !rst && (count != 2'd0);

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter: idle port, gap fill, starvation,
// squash, zero/same-address drops, full queue and reset.
module tb_wb_port_arbiter;

    logic        clk;
    logic        rst;
    logic        p_we;
    logic [4:0]  p_wa;
    logic [31:0] p_wd;
    logic        m_valid;
    logic [4:0]  m_wa;
    logic [31:0] m_wd;
    logic        m_ready;
    logic        stall_req;
    logic        rf_we;
    logic [4:0]  rf_wa;
    logic [31:0] rf_wd;
    logic        pending;

    int npass = 0;
    int ntot  = 0;

    wb_port_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .p_we      (p_we),
        .p_wa      (p_wa),
        .p_wd      (p_wd),
        .m_valid   (m_valid),
        .m_wa      (m_wa),
        .m_wd      (m_wd),
        .m_ready   (m_ready),
        .stall_req (stall_req),
        .rf_we     (rf_we),
        .rf_wa     (rf_wa),
        .rf_wd     (rf_wd),
        .pending   (pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        ntot++;
        assert (obs === exp) npass++;
        else $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    endtask

    task automatic drv(input logic pwe, input logic [4:0] pwa,
                       input logic [31:0] pwd, input logic mv,
                       input logic [4:0] mwa, input logic [31:0] mwd);
        p_we    = pwe;
        p_wa    = pwa;
        p_wd    = pwd;
        m_valid = mv;
        m_wa    = mwa;
        m_wd    = mwd;
        #4;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        drv(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        tick();
        drv(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        chk("rst_m_ready", m_ready, 0);
        chk("rst_stall", stall_req, 0);
        chk("rst_rf_we", rf_we, 0);
        chk("rst_pending", pending, 0);
        tick();
        rst = 1'b0;
        drv(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        chk("post_rst_m_ready", m_ready, 1);
        chk("post_rst_pending", pending, 0);
        tick();

        // idle port: pipeline write passes straight through
        drv(1'b1, 5'd8, 32'hAA, 1'b0, 5'd0, 32'h0);
        chk("idle_we", rf_we, 1);
        chk("idle_wa", rf_wa, 8);
        chk("idle_wd", rf_wd, 32'hAA);
        chk("idle_pending", pending, 0);
        tick();

        // gap fill
        drv(1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 32'h11);
        chk("gap_push_we", rf_we, 0);
        chk("gap_push_ready", m_ready, 1);
        tick();
        drv(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        chk("gap_pending", pending, 1);
        chk("gap_we", rf_we, 1);
        chk("gap_wa", rf_wa, 3);
        chk("gap_wd", rf_wd, 32'h11);
        chk("gap_stall", stall_req, 0);
        tick();
        drv(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        chk("gap_after_pending", pending, 0);
        tick();

        // starvation: head forced 4 cycles after its push
        drv(1'b1, 5'd9, 32'h99, 1'b1, 5'd5, 32'h22);
        chk("starve_c0_wa", rf_wa, 9);
        tick();
        for (int c = 1; c <= 3; c++) begin
            drv(1'b1, 5'd9, 32'h99, 1'b0, 5'd0, 32'h0);
            chk($sformatf("starve_c%0d_stall", c), stall_req, 0);
            chk($sformatf("starve_c%0d_wa", c), rf_wa, 9);
            chk($sformatf("starve_c%0d_pend", c), pending, 1);
            tick();
        end
        drv(1'b1, 5'd9, 32'h99, 1'b0, 5'd0, 32'h0);
        chk("starve_c4_stall", stall_req, 1);
        chk("starve_c4_we", rf_we, 1);
        chk("starve_c4_wa", rf_wa, 5);
        chk("starve_c4_wd", rf_wd, 32'h22);
        tick();
        drv(1'b1, 5'd9, 32'h99, 1'b0, 5'd0, 32'h0);
        chk("starve_c5_stall", stall_req, 0);
        chk("starve_c5_we", rf_we, 1);
        chk("starve_c5_wa", rf_wa, 9);
        chk("starve_c5_pend", pending, 0);
        tick();

        // squash: queued r7 overtaken by pipeline write to r7
        drv(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 32'h33);
        tick();
        drv(1'b1, 5'd7, 32'h44, 1'b0, 5'd0, 32'h0);
        chk("squash_we", rf_we, 1);
        chk("squash_wa", rf_wa, 7);
        chk("squash_wd", rf_wd, 32'h44);
        chk("squash_pend", pending, 1);
        tick();
        drv(1'b1, 5'd10, 32'h55, 1'b0, 5'd0, 32'h0);
        chk("squash_pipe_wa", rf_wa, 10);
        chk("squash_pipe_wd", rf_wd, 32'h55);
        chk("squash_pend2", pending, 1);
        tick();
        drv(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        chk("squash_popped", pending, 0);
        chk("squash_no_write", rf_we, 0);
        tick();

        // zero address and same-cycle same-address results are dropped
        drv(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'h77);
        chk("zero_ready", m_ready, 1);
        tick();
        drv(1'b1, 5'd12, 32'h12, 1'b1, 5'd12, 32'h88);
        chk("zero_not_queued", pending, 0);
        tick();
        drv(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        chk("same_not_queued", pending, 0);
        tick();

        // p_wa=0 does not block the head
        drv(1'b0, 5'd0, 32'h0, 1'b1, 5'd4, 32'h66);
        tick();
        drv(1'b1, 5'd0, 32'hFF, 1'b0, 5'd0, 32'h0);
        chk("r0_we", rf_we, 1);
        chk("r0_wa", rf_wa, 4);
        chk("r0_wd", rf_wd, 32'h66);
        tick();

        // full queue, then reset with two entries queued
        drv(1'b1, 5'd20, 32'h20, 1'b1, 5'd1, 32'h01);
        tick();
        drv(1'b1, 5'd20, 32'h20, 1'b1, 5'd2, 32'h02);
        chk("one_ready", m_ready, 1);
        tick();
        drv(1'b1, 5'd20, 32'h20, 1'b0, 5'd0, 32'h0);
        chk("full_ready", m_ready, 0);
        chk("full_pend", pending, 1);
        tick();
        rst = 1'b1;
        drv(1'b1, 5'd20, 32'h20, 1'b1, 5'd3, 32'h03);
        chk("rst_full_ready", m_ready, 0);
        chk("rst_full_we", rf_we, 0);
        chk("rst_full_pend", pending, 0);
        tick();
        rst = 1'b0;
        drv(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        chk("after_rst_pend", pending, 0);
        chk("after_rst_we", rf_we, 0);
        chk("after_rst_stall", stall_req, 0);
        chk("after_rst_ready", m_ready, 1);
        tick();

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
